stream_frame_source: RTL and testbench
======================================

Name: stream_frame_source

Overview:
- Transmitter end of the layer-chain AXI-stream-style interface: holds one input frame in on-chip RAM and streams it out on m_data_out/m_valid/m_ready, feeding the s_data_in_x port of a multi-layer accelerator.
- The frame is loaded through a simple write port, then sent on a start pulse.
- Sustains one word per cycle under continuous m_ready and tolerates arbitrary backpressure, despite the RAM's 1-cycle synchronous read.

Parameters:
- T, 16, data word width in bits.
- NUMVALS, 9984, words per frame (RAM depth); must be at least 1.
- ADDRW, $clog2(NUMVALS), address width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  frame-RAM write strobe.
- wr_addr  input  ADDRW  write address.
- wr_data  input  T  write data.
- start  input  1  single-cycle pulse that begins transmission of words 0..NUMVALS-1.
- busy  output  1  high from the accepted start until the last word handshakes.
- done  output  1  one-cycle pulse in the cycle after the last word's handshake.
- m_data_out  output  T  stream data (signed two's complement; passed through unmodified).
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the downstream receiver.
- m_last  output  1  high with the word at index NUMVALS-1.

Behaviour:
- Reset (async, active-high): clear FSM to IDLE, rd_ptr=0, buffer empty, in-flight=0. Outputs: busy=0, done=0, m_valid=0, m_last=0, m_data_out=0. RAM contents are not cleared.
- FSM states:
  - IDLE: start=1 moves to STREAM; rd_ptr=0; busy=1 from the next cycle.
  - STREAM: issues RAM reads. When the read of address NUMVALS-1 issues, move to DRAIN.
  - DRAIN: no new reads. When the last word handshakes (m_valid & m_ready & m_last), move to IDLE; busy=0 and done=1 in the next cycle.
- Read issue:
  - Read address rd_ptr is issued only when (buffer occupancy + in-flight reads) < 2.
  - Read data lands in a 2-entry output buffer one cycle later.
  - rd_ptr increments on each issue.
- Output:
  - m_valid = buffer not empty; m_data_out/m_last come from the buffer head.
  - The head pops on m_valid & m_ready.
  - A pop and a push in the same cycle are both honoured; occupancy stays unchanged.
  - Once m_valid is asserted, m_data_out and m_last stay stable until the handshake. m_valid is never dropped without a handshake.
- Latency and throughput:
  - start at edge N: first read issues in cycle N+1, m_valid=1 from cycle N+2.
  - With m_ready held high, one word per cycle; the last handshake is at cycle N+1+NUMVALS.
- Backpressure:
  - m_ready low for any duration: at most 2 words buffered, no word lost or duplicated, reads stall.
  - On m_ready return, transfer resumes at full rate with no bubble.
- start handling: start while busy=1 is ignored. start in the same cycle as the done pulse is accepted (FSM already in IDLE).
- Writes:
  - wr_en while busy=1 is ignored; the RAM is unchanged, so the frame stays consistent.
  - A write in IDLE takes effect on that edge; a read issued on the next cycle sees the new data.
  - wr_addr >= NUMVALS is ignored.
- NUMVALS=1: STREAM issues a single read and goes directly to DRAIN; that word carries m_last=1.
- Reset mid-frame: transfer aborts immediately and all outputs return to their reset values. Next start re-sends from word 0.

Decomposition:
- Shared package stream_pkg holds:
  - typedef state_t {IDLE, STREAM, DRAIN};
  - the data word type logic signed [T-1:0] for the default T=16.
- One natural sub-module, frame_ram: single-port-write / single-port-read synchronous RAM, 1-cycle read latency, no reset on the array.
- The FSM, rd_ptr, and the 2-entry skid buffer stay in stream_frame_source.

Test Plan:
- Load NUMVALS=8 words 0x0001..0x0008, start, m_ready=1 constant -> m_valid rises 2 cycles after start; 8 consecutive beats 0x0001..0x0008; m_last on 0x0008 only; done pulses 1 cycle later; busy low thereafter.
- Same frame, m_ready toggled randomly each cycle (per-cycle random, 50%) -> exactly 8 beats in order, no duplicates; m_data_out stable while m_valid & ~m_ready.
- m_ready held low 20 cycles mid-frame after word 3 -> m_valid stays 1 with 0x0004 held; next beats are 0x0004, 0x0005 back-to-back with no bubble.
- start pulsed again during transmission, plus wr_en to addr 5 with 0xBEEF while busy -> ignored; frame still ends at 0x0008 with a single done; a later frame reads 0x0006 at addr 5.
- Assert reset while word 4 is pending, then start -> m_valid=0, busy=0 during reset; new frame begins at 0x0001.
- Default NUMVALS=9984 loaded from the layer's .in vector file, random m_ready -> all 9984 words match the file; m_last only on index 9983.

Source files
------------

// File: rtl/stream_frame_source_pkg.sv
// Shared types for the frame-source stream transmitter.
package stream_pkg;

    localparam int WORD_W = 16;

    // Stream data word for the default width: signed two's complement, passed through unmodified.
    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_frame_source_frame_ram.sv
// Frame storage: one write port, one read port, registered read data (1-cycle latency).
// The array has no reset, so frame contents survive a reset.
module frame_ram #(
    parameter int T     = 16,
    parameter int DEPTH = 9984,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [T-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [T-1:0]  rdata
);

    logic [T-1:0] mem_r [DEPTH];

    // Write port and registered read port; read data holds when no read is issued.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/stream_frame_source.sv
// Stream transmitter: sends a RAM-held frame on a valid/ready stream after a start pulse.
// The word currently in the RAM read register counts as "in flight"; together with the
// 2-entry skid buffer it forms a queue of at most two words, so reads stall under
// backpressure and resume without a bubble.
module stream_frame_source
    import stream_pkg::*;
#(
    parameter int T       = 16,
    parameter int NUMVALS = 9984,
    parameter int ADDRW   = (NUMVALS > 1) ? $clog2(NUMVALS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [T-1:0]     wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [T-1:0]     m_data_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NUMVALS - 1);
    localparam logic [ADDRW:0]   WR_LIMIT  = (ADDRW + 1)'(NUMVALS);

    state_t           state_r;
    state_t           state_next_s;
    logic             busy_r;
    logic             busy_next_s;
    logic             done_r;
    logic             done_next_s;
    logic [ADDRW-1:0] rd_ptr_r;
    logic             inflight_r;
    logic             inflight_last_r;
    logic [T-1:0]     buf_data_r [2];
    logic             buf_last_r [2];
    logic             head_r;
    logic [1:0]       count_r;
    logic [T-1:0]     ram_rdata_s;
    logic             ram_we_s;
    logic             issue_s;
    logic             last_issue_s;
    logic             valid_s;
    logic             pop_s;
    logic             pop_buf_s;
    logic             push_s;
    logic             wr_idx_s;
    logic [T-1:0]     head_data_s;
    logic             head_last_s;

    // Writes only land while idle and in range, so a frame in flight stays consistent.
    assign ram_we_s     = wr_en & ~busy_r & ({1'b0, wr_addr} < WR_LIMIT);
    assign issue_s      = (state_r == STREAM) && ((count_r + {1'b0, inflight_r}) < 2'd2);
    assign last_issue_s = issue_s && (rd_ptr_r == LAST_ADDR);
    assign valid_s      = (count_r != 2'd0) | inflight_r;
    assign pop_s        = valid_s & m_ready;
    assign pop_buf_s    = pop_s & (count_r != 2'd0);
    // An in-flight word consumed straight from the RAM register never enters the buffer.
    assign push_s       = inflight_r & ~(pop_s & (count_r == 2'd0));
    assign wr_idx_s     = head_r ^ count_r[0];

    frame_ram #(
        .T     (T),
        .DEPTH (NUMVALS),
        .AW    (ADDRW)
    ) u_frame_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (issue_s),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    // Queue head: oldest buffered word, else the in-flight RAM word, else zero.
    always_comb begin
        head_data_s = '0;
        head_last_s = 1'b0;
        if (count_r != 2'd0) begin
            head_data_s = buf_data_r[head_r];
            head_last_s = buf_last_r[head_r];
        end else if (inflight_r) begin
            head_data_s = ram_rdata_s;
            head_last_s = inflight_last_r;
        end else begin
            head_data_s = '0;
            head_last_s = 1'b0;
        end
    end

    assign m_valid    = valid_s;
    assign m_data_out = head_data_s;
    assign m_last     = head_last_s;
    assign busy       = busy_r;
    assign done       = done_r;

    // Next-state logic: IDLE -> STREAM on start, STREAM -> DRAIN on last read, DRAIN -> IDLE on last handshake.
    always_comb begin
        state_next_s = state_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = STREAM;
                    busy_next_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (last_issue_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = STREAM;
                end
            end
            DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_next_s = IDLE;
                    busy_next_s  = 1'b0;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State, status flags and read pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            rd_ptr_r <= '0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
            if ((state_r == IDLE) && start) begin
                rd_ptr_r <= '0;
            end else if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + ADDRW'(1);
            end
        end
    end

    // In-flight tracking and the 2-entry skid buffer (pop and push may share a cycle).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            head_r          <= 1'b0;
            count_r         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_r[i] <= '0;
                buf_last_r[i] <= 1'b0;
            end
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= last_issue_s;
            if (push_s) begin
                buf_data_r[wr_idx_s] <= ram_rdata_s;
                buf_last_r[wr_idx_s] <= inflight_last_r;
            end
            head_r  <= head_r ^ pop_buf_s;
            count_r <= count_r + 2'(push_s) - 2'(pop_buf_s);
        end
    end

endmodule

// File: tb/tb_stream_frame_source.sv
// Directed bench for stream_frame_source: an 8-word instance for the detailed
// cases and a default-size instance for a full-frame run under random backpressure.
module tb_stream_frame_source;

    localparam int NV  = 8;
    localparam int AW  = 3;
    localparam int BNV = 9984;
    localparam int BAW = 14;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_last;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          wr_en, start, busy, done, m_valid, m_ready, m_last;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data, m_data_out;

    logic           b_wr_en, b_start, b_busy, b_done, b_valid, b_ready, b_last;
    logic [BAW-1:0] b_wr_addr;
    logic [15:0]    b_wr_data, b_data;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_mem [NV];
    logic [15:0] b_exp [BNV];
    vec_t        vt [10];

    stream_frame_source #(.T(16), .NUMVALS(NV)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .m_data_out(m_data_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    stream_frame_source dut_big (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .start(b_start), .busy(b_busy), .done(b_done), .m_data_out(b_data),
        .m_valid(b_valid), .m_ready(b_ready), .m_last(b_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full frame on the small instance. mode 0: ready high, 1: random ready,
    // 2: 20-cycle stall after word 3, 3: start and write poked while busy.
    task automatic stream_frame(input int mode);
        int          beats = 0;
        int          cyc = 0;
        int          stall = 0;
        logic        got_last = 1'b0;
        logic        poked = 1'b0;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic        pl = 1'b0;
        logic [15:0] pd = 16'h0000;
        @(negedge clk); start = 1'b1; m_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("lat_valid_n1", m_valid, 1'b0);
        chk("lat_busy_n1", busy, 1'b1);
        while (!got_last && cyc < 200) begin
            @(negedge clk);
            cyc++;
            wr_en = 1'b0; start = 1'b0;
            case (mode)
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (beats == 3 && stall < 20) begin
                        m_ready = 1'b0;
                        stall++;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: m_ready = 1'b1;
            endcase
            if (mode == 3 && beats == 2 && !poked) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; poked = 1'b1;
            end
            if (cyc == 1) chk("lat_valid_n2", m_valid, 1'b1);
            if (pv && !pr) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data_out, pd);
                chk("hold_last", m_last, pl);
            end
            if (mode == 2 && !m_ready) chk("stall_word4", m_data_out, 16'h0004);
            if (mode == 2 && stall == 20 && beats < 5) chk("no_bubble", m_valid, 1'b1);
            chk("busy_in_frame", busy, 1'b1);
            chk("no_early_done", done, 1'b0);
            if (m_valid && m_ready) begin
                chk("beat_in_range", beats < NV, 1'b1);
                if (beats < NV) begin
                    chk("beat_data", m_data_out, exp_mem[beats]);
                    chk("beat_last", m_last, beats == NV - 1);
                end
                if (m_last) got_last = 1'b1;
                beats++;
            end
            pv = m_valid; pr = m_ready; pd = m_data_out; pl = m_last;
        end
        chk("frame_complete", got_last, 1'b1);
        chk("beat_count", beats, NV);
        @(negedge clk); m_ready = 1'b0; wr_en = 1'b0; start = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("busy_clear", busy, 1'b0);
        chk("valid_clear", m_valid, 1'b0);
        @(negedge clk);
        chk("done_single", done, 1'b0);
        chk("idle_after", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int b_beats;
        logic b_got_last;
        for (int i = 0; i < NV; i++) exp_mem[i] = 16'(i + 1);
        vt[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        for (int k = 1; k <= 8; k++) vt[k] = '{1'b1, 1'b1, 16'(k), (k == 8), 1'b1, 1'b0};
        vt[9] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; m_ready = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0; b_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_data", m_data_out, 16'h0000);
        chk("rst_last", m_last, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_addr = AW'(i); wr_data = exp_mem[i];
        end
        @(negedge clk); wr_en = 1'b0;

        // Table-driven run with ready held high; a start on the done cycle is accepted.
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            m_ready = vt[k].ready;
            chk("tbl_valid", m_valid, vt[k].exp_valid);
            chk("tbl_busy", busy, vt[k].exp_busy);
            chk("tbl_done", done, vt[k].exp_done);
            if (vt[k].exp_valid) begin
                chk("tbl_data", m_data_out, vt[k].exp_data);
                chk("tbl_last", m_last, vt[k].exp_last);
            end
            if (k == 9) start = 1'b1;
        end
        @(negedge clk); start = 1'b0;
        chk("start_on_done", busy, 1'b1);
        hs = 0;
        for (int c = 0; c < 30 && hs == 0; c++) begin
            @(negedge clk);
            if (m_valid && m_ready && m_last) hs = 1;
        end
        chk("restart_finished", hs, 1);
        @(negedge clk); m_ready = 1'b0;
        chk("restart_done", done, 1'b1);

        stream_frame(1);
        stream_frame(2);
        stream_frame(3);
        stream_frame(0);

        // Reset while word 4 is pending, then a fresh frame from word 0.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; m_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) hs++;
        end
        @(negedge clk); m_ready = 1'b0;
        chk("pending_valid", m_valid, 1'b1);
        chk("pending_word4", m_data_out, 16'h0004);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("midrst_valid", m_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", m_data_out, 16'h0000);
        chk("midrst_last", m_last, 1'b0);
        @(negedge clk);
        chk("midrst_hold", m_valid, 1'b0);
        reset = 1'b0;
        stream_frame(0);

        // Default-size frame under random backpressure.
        for (int i = 0; i < BNV; i++) begin
            b_exp[i] = 16'(i * 40503 + 12345);
            @(negedge clk); b_wr_en = 1'b1; b_wr_addr = BAW'(i); b_wr_data = b_exp[i];
        end
        @(negedge clk); b_wr_en = 1'b0; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        b_beats = 0; b_got_last = 1'b0;
        for (int c = 0; c < 60000 && !b_got_last; c++) begin
            @(negedge clk);
            b_ready = 1'($urandom_range(0, 1));
            if (b_valid && b_ready) begin
                if (b_beats < BNV) begin
                    chk("big_data", b_data, b_exp[b_beats]);
                    chk("big_last", b_last, b_beats == BNV - 1);
                end else begin
                    chk("big_extra_beat", b_beats, BNV - 1);
                end
                if (b_last) b_got_last = 1'b1;
                b_beats++;
            end
        end
        chk("big_complete", b_got_last, 1'b1);
        chk("big_count", b_beats, BNV);
        @(negedge clk); b_ready = 1'b0;
        chk("big_done", b_done, 1'b1);
        chk("big_busy_clear", b_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
